// File: rtl/npu_weight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : npu_weight_sequencer
//  Description : Walks a contiguous window of the NPU weight ROM, issuing one
//                synchronous read per cycle. Read data is buffered in a
//                2-entry FIFO that absorbs the 1-cycle ROM latency, and is
//                streamed to the MAC array over valid/ready with neuron-group
//                and end-of-job tags.
//                Optional feature macro: WEIGHT_SEQ_STALL_CNT_EN adds a
//                16-bit saturating stall_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module npu_weight_sequencer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_weights,
    input  logic [7:0]        group_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last_group,
    output logic              w_last
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W+1:0] c_depth   = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Latched job descriptor and progress counters
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_num;
    logic [7:0]        r_glen;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_beats;
    logic [7:0]        r_group;
    logic              r_err;
    logic              r_inflight;

    // 2-entry output FIFO
    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic [ADDR_W+1:0] w_job_end;
    logic              w_illegal;
    logic              w_accept;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_room;

    // Job legality: the window must lie entirely inside the store (no wrap)
    assign w_job_end = {2'b00, base_addr} + {1'b0, num_weights};
    assign w_illegal = (num_weights == '0)
                    || ({1'b0, num_weights} > c_depth)
                    || (w_job_end > c_depth)
                    || (group_len == 8'd0);
    assign w_accept  = (r_state == S_IDLE) && start;

    assign w_valid   = (r_count != 2'd0);
    assign w_data    = r_mem[r_rd_ptr];
    assign w_pop     = w_valid && w_ready;

    // Slots already committed (stored + in flight), minus the one leaving now
    assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_room    = (w_occ < (3'd2 + {2'b00, w_pop}));

    assign rom_addr  = r_base + r_issued[ADDR_W-1:0];
    assign err       = r_err;

    assign w_last       = w_valid && ((r_beats + c_cnt_one) == r_num);
    assign w_last_group = w_valid && (((r_group + 8'd1) == r_glen) || w_last);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        rom_rd_en   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_illegal ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (w_room) begin
                    rom_rd_en = 1'b1;
                    if ((r_issued + c_cnt_one) == r_num) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job descriptor latch, error flag and read/beat/group counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_num    <= '0;
            r_glen   <= '0;
            r_issued <= '0;
            r_beats  <= '0;
            r_group  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_issued <= '0;
            r_beats  <= '0;
            r_group  <= '0;
            if (w_illegal) begin
                r_err <= 1'b1;
            end else begin
                r_err  <= 1'b0;
                r_base <= base_addr;
                r_num  <= num_weights;
                r_glen <= group_len;
            end
        end else begin
            if (rom_rd_en) begin
                r_issued <= r_issued + c_cnt_one;
            end
            if (w_pop) begin
                r_beats <= r_beats + c_cnt_one;
                r_group <= w_last_group ? 8'd0 : (r_group + 8'd1);
            end
        end
    end

    // In-flight flag marks the cycle in which rom_data must be captured
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rom_rd_en;
        end
    end

    // Output FIFO: write returning ROM data, pop on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= rom_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturating count of cycles the consumer held off a valid beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= 16'd0;
        end else if (w_accept) begin
            r_stall <= 16'd0;
        end else if (w_valid && !w_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npu_weight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_weight_sequencer
//  Description : Scoreboard bench for npu_weight_sequencer. Jobs push their
//                expected read addresses and beats into queues; a monitor
//                pops and compares on every read strobe and beat handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_weight_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_weights;
    logic [7:0]  group_len;
    logic        busy;
    logic        done;
    logic        err;
    logic        rom_rd_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic        w_last_group;
    logic        w_last;
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        lg;
        logic        last;
    } beat_t;

    beat_t      beat_q[$];
    logic [7:0] addr_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beats_seen = 0;
    int first_beat_cyc = -1;
    int rd_seen = 0;
    int done_seen = 0;
    int exp_stall = 0;
    int ready_mode = 0;
    int ph = 0;
    bit    prev_hold = 1'b0;
    beat_t prev_beat;

    npu_weight_sequencer #(
        .DATA_W (16),
        .DEPTH  (192),
        .ADDR_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_weights  (num_weights),
        .group_len    (group_len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rom_rd_en    (rom_rd_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .w_last_group (w_last_group),
        .w_last       (w_last)
`ifdef WEIGHT_SEQ_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    function automatic logic [15:0] rom_fn(input int a);
        return 16'((a * 311) ^ 16'h5A00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous weight ROM model
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom_fn(int'(rom_addr));
    end

    // Consumer ready: free-running, or the repeating 1,0,0,1 pattern
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0) begin
                w_ready = 1'b1;
            end else begin
                w_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
        end
    end

    // Monitor: compare reads and beats against the scoreboard queues
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (rom_rd_en) begin
                rd_seen++;
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", rom_addr);
                end else begin
                    check("rom_addr", {24'd0, rom_addr}, {24'd0, addr_q.pop_front()});
                end
            end
            if (prev_hold) begin
                check("hold_valid", {31'd0, w_valid}, 32'd1);
                check("hold_beat", {14'd0, w_data, w_last_group, w_last}, {14'd0, prev_beat});
            end
            if (w_valid && w_ready) begin
                beats_seen++;
                if (beats_seen == 1) first_beat_cyc = cyc;
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", w_data);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("w_data", {16'd0, w_data}, {16'd0, b.d});
                    check("w_last_group", {31'd0, w_last_group}, {31'd0, b.lg});
                    check("w_last", {31'd0, w_last}, {31'd0, b.last});
                end
            end
            if (w_valid && !w_ready) exp_stall++;
            if (done) done_seen++;
            prev_hold = w_valid && !w_ready;
            prev_beat = {w_data, w_last_group, w_last};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic push_expected(input int base, input int num, input int glen);
        beat_t b;
        for (int i = 0; i < num; i++) begin
            addr_q.push_back(8'(base + i));
            b.d    = rom_fn(base + i);
            b.lg   = (((i + 1) % glen) == 0) || (i == num - 1);
            b.last = (i == num - 1);
            beat_q.push_back(b);
        end
    endtask

    task automatic issue_start(input int base, input int num, input int glen, input int mode, output int t0);
        @(posedge clk);
        #1;
        ready_mode     = mode;
        ph             = 0;
        beats_seen     = 0;
        first_beat_cyc = -1;
        rd_seen        = 0;
        exp_stall      = 0;
        done_seen      = 0;
        base_addr      = 8'(base);
        num_weights    = 9'(num);
        group_len      = 8'(glen);
        start          = 1'b1;
        t0             = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int base, input int num, input int glen,
                           input int mode, input bit extra, input bit exp_err);
        int t0;
        bit got;
        if (!exp_err) push_expected(base, num, glen);
        issue_start(base, num, glen, mode, t0);
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else if (extra && k == 4) begin
                base_addr   = 8'd0;
                num_weights = 9'd3;
                start       = 1'b1;
            end else if (extra && k == 5) begin
                start = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end else begin
            check("done_err", {31'd0, err}, {31'd0, exp_err});
            check("done_busy", {31'd0, busy}, 32'd0);
            if (mode == 0) check("done_cycle", cyc - t0, exp_err ? 1 : num + 3);
            if (!exp_err && mode == 0) check("first_beat_cycle", first_beat_cyc - t0, 3);
            check("beat_count", beats_seen, exp_err ? 0 : num);
            check("read_count", rd_seen, exp_err ? 0 : num);
            check("beats_left", beat_q.size(), 0);
`ifdef WEIGHT_SEQ_STALL_CNT_EN
            check("stall_cnt", {16'd0, stall_cnt}, exp_stall);
`endif
            if (extra) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_pulse_width", {31'd0, done}, 32'd0);
            check("idle_after_done", {31'd0, busy}, 32'd0);
            check("err_held", {31'd0, err}, {31'd0, exp_err});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, rom_rd_en}, 32'd0);
        check({tag, "_rom_addr"}, {24'd0, rom_addr}, 32'd0);
        check({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_w_data"}, {16'd0, w_data}, 32'd0);
        check({tag, "_w_last_group"}, {31'd0, w_last_group}, 32'd0);
        check({tag, "_w_last"}, {31'd0, w_last}, 32'd0);
    endtask

    initial begin
        int t0;
        int d0;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = 8'd0;
        num_weights = 9'd0;
        group_len   = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full store, free-running consumer, groups of 64
        run_job(0, 192, 64, 0, 1'b0, 1'b0);
        // Backpressure with a partial final group
        run_job(10, 8, 3, 1, 1'b0, 1'b0);
        // Window runs past the end of the store
        run_job(190, 5, 4, 0, 1'b0, 1'b1);
        // Legal job clears err
        run_job(0, 4, 2, 0, 1'b0, 1'b0);
        // Bad lengths
        run_job(0, 0, 4, 0, 1'b0, 1'b1);
        run_job(0, 5, 0, 0, 1'b0, 1'b1);
        run_job(0, 193, 1, 0, 1'b0, 1'b1);
        // Window ending exactly at the last word is legal
        run_job(185, 7, 7, 0, 1'b0, 1'b0);

        // Reset in the middle of a 20-beat job
        push_expected(20, 20, 5);
        issue_start(20, 20, 5, 0, t0);
        for (int k = 0; k < 200 && beats_seen < 4; k++) @(negedge clk);
        check("beats_before_reset", {31'd0, beats_seen >= 4}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        beat_q.delete();
        addr_q.delete();
        d0 = done_seen;
        @(negedge clk);
        check_all_zero("midjob_reset");
        repeat (6) @(negedge clk);
        check("no_done_after_reset", done_seen, d0);
        check("no_valid_after_reset", {31'd0, w_valid}, 32'd0);

        // Replay from base with fresh counters
        run_job(20, 20, 5, 0, 1'b0, 1'b0);
        // Second start mid-job and during DONE is ignored
        run_job(30, 12, 5, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
